// File: rtl/risc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RISC control FSM.
package risc_ctrl_pkg;

  localparam int OPC_BITS = 6;
  localparam int ALU_BITS = 2;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_e;

  localparam logic [OPC_BITS-1:0] OP_R    = 6'b000000;
  localparam logic [OPC_BITS-1:0] OP_LW   = 6'b100011;
  localparam logic [OPC_BITS-1:0] OP_SW   = 6'b101011;
  localparam logic [OPC_BITS-1:0] OP_ADDI = 6'b100001;
  localparam logic [OPC_BITS-1:0] OP_BEQ  = 6'b000100;

  localparam logic [ALU_BITS-1:0] ALU_ADD  = 2'b00;
  localparam logic [ALU_BITS-1:0] ALU_ADDI = 2'b01;
  localparam logic [ALU_BITS-1:0] ALU_ADDR = 2'b10;
  localparam logic [ALU_BITS-1:0] ALU_SUB  = 2'b11;

  // Decoded view of one opcode; datapath selects are raw (ungated by state)
  typedef struct packed {
    logic legal;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic sel2;
    logic sel3;
    logic sel4;
  } dec_t;

endpackage

// File: rtl/risc_op_decode.sv
// Combinational opcode decoder: classifies the opcode and produces the
// datapath select pattern and ALU op for it.
module risc_op_decode
  import risc_ctrl_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int ALUOP_W = 2,
  parameter bit EN_BEQ  = 1'b1
) (
  input  logic [OPC_W-1:0]   op_i,
  output dec_t               dec_o,
  output logic [ALUOP_W-1:0] alu_op_o
);

  // Opcode classification; anything unmatched stays illegal
  always_comb begin
    dec_o    = '0;
    alu_op_o = '0;
    if (op_i == OPC_W'(OP_R)) begin
      dec_o.legal = 1'b1;
      dec_o.sel2  = 1'b1;
      alu_op_o    = ALUOP_W'(ALU_ADD);
    end else if (op_i == OPC_W'(OP_ADDI)) begin
      dec_o.legal = 1'b1;
      dec_o.sel3  = 1'b1;
      alu_op_o    = ALUOP_W'(ALU_ADDI);
    end else if (op_i == OPC_W'(OP_LW)) begin
      dec_o.legal = 1'b1;
      dec_o.is_lw = 1'b1;
      dec_o.sel3  = 1'b1;
      dec_o.sel4  = 1'b1;
      alu_op_o    = ALUOP_W'(ALU_ADDR);
    end else if (op_i == OPC_W'(OP_SW)) begin
      dec_o.legal = 1'b1;
      dec_o.is_sw = 1'b1;
      dec_o.sel3  = 1'b1;
      alu_op_o    = ALUOP_W'(ALU_ADDR);
    end else if (EN_BEQ && (op_i == OPC_W'(OP_BEQ))) begin
      dec_o.legal  = 1'b1;
      dec_o.is_beq = 1'b1;
      alu_op_o     = ALUOP_W'(ALU_SUB);
    end
  end

endmodule

// File: rtl/risc_multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshakes, handshake timeout and illegal-opcode trap.
module risc_multicycle_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int ALUOP_W = 2,
  parameter int TIMEOUT = 15,
  parameter bit EN_BEQ  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic               alu_zero_i,
  input  logic               imem_ready_i,
  input  logic               dmem_ready_i,
  input  logic               trap_clr_i,
  output logic               imem_req_o,
  output logic               ir_we_o,
  output logic               pc_we_o,
  output logic               cs_o,
  output logic               rd2_o,
  output logic               wr2_o,
  output logic               wr1_o,
  output logic               sel2_o,
  output logic               sel3_o,
  output logic               sel4_o,
  output logic               sel5_o,
  output logic               branch_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               illegal_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q;
  logic [OPC_W-1:0]   op_q;
  logic [CNT_W-1:0]   wait_cnt_q;

  logic [OPC_W-1:0]   dec_op;
  dec_t               dec;
  logic [ALUOP_W-1:0] dec_alu;
  logic               wait_hit;
  logic               dp_act;
  logic               beq_take;

  // In DECODE the live opcode is classified (it is being latched this edge);
  // everywhere else the latched op_q drives the selects.
  assign dec_op = (state_q == DECODE) ? opcode_i : op_q;

  risc_op_decode #(
    .OPC_W  (OPC_W),
    .ALUOP_W(ALUOP_W),
    .EN_BEQ (EN_BEQ)
  ) u_dec (
    .op_i    (dec_op),
    .dec_o   (dec),
    .alu_op_o(dec_alu)
  );

  // This waiting cycle is the TIMEOUT-th one: a still-low ready traps,
  // a ready arriving in this same cycle still advances normally.
  assign wait_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  // State, latched opcode and handshake wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RST;
      op_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= '0;
      case (state_q)
        S_RST: state_q <= FETCH;
        FETCH: begin
          if (imem_ready_i)  state_q <= DECODE;
          else if (wait_hit) state_q <= TRAP;
          else               wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
        DECODE: begin
          op_q    <= opcode_i;
          state_q <= dec.legal ? EXEC : TRAP;
        end
        EXEC: begin
          if (dec.is_lw || dec.is_sw) state_q <= MEM;
          else if (dec.is_beq)        state_q <= FETCH;
          else                        state_q <= WB;
        end
        MEM: begin
          if (dmem_ready_i)  state_q <= dec.is_lw ? WB : FETCH;
          else if (wait_hit) state_q <= TRAP;
          else               wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
        WB:      state_q <= FETCH;
        TRAP:    if (trap_clr_i) state_q <= FETCH;
        default: state_q <= S_RST;
      endcase
    end
  end

  assign dp_act   = (state_q == EXEC) || (state_q == MEM) || (state_q == WB);
  assign beq_take = (state_q == EXEC) && dec.is_beq && alu_zero_i;

  // Moore strobes from state/op_q, plus the ready/zero qualified strobes
  always_comb begin
    imem_req_o = (state_q == FETCH);
    ir_we_o    = (state_q == FETCH) && imem_ready_i;
    pc_we_o    = ((state_q == FETCH) && imem_ready_i) || beq_take;
    sel5_o     = beq_take;
    branch_o   = (state_q == EXEC) && dec.is_beq;
    cs_o       = (state_q == MEM);
    rd2_o      = (state_q == MEM) && dec.is_lw;
    wr2_o      = (state_q == MEM) && dec.is_sw;
    wr1_o      = (state_q == WB);
    sel2_o     = dp_act && dec.sel2;
    sel3_o     = dp_act && dec.sel3;
    sel4_o     = dp_act && dec.sel4;
    alu_op_o   = dp_act ? dec_alu : '0;
    illegal_o  = (state_q == TRAP);
    busy_o     = (state_q != S_RST) && (state_q != TRAP);
  end

endmodule
